// File: rtl/truth_table_sequencer_pkg.sv
// Shared types and sizing helpers for the truth-table sequencer.
package truth_table_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } seq_state_t;

  // Sweep length for a gate with n inputs.
  function automatic int tt_vecs(input int n);
    return 1 << n;
  endfunction

  // Counter width able to hold settle-1.
  function automatic int cnt_width(input int settle);
    return (settle > 1) ? $clog2(settle) : 1;
  endfunction

endpackage

// File: rtl/truth_table_sequencer_if.sv
// Control/result and gate-side signals of the sequencer; slave = sequencer, master = control source plus gate.
interface truth_table_sequencer_if #(
  parameter int N_INPUTS = 2
);
  import truth_table_sequencer_pkg::*;

  localparam int V = tt_vecs(N_INPUTS);

  logic                start;
  logic                abort;
  logic [N_INPUTS-1:0] dut_in;
  logic                dut_out;
  logic                busy;
  logic                done;
  logic                result_valid;
  logic                pass;
  logic [V-1:0]        captured;
  logic [V-1:0]        fail_vec;

  modport slave (
    input  start, abort, dut_out,
    output dut_in, busy, done, result_valid, pass, captured, fail_vec
  );

  modport master (
    output start, abort, dut_out,
    input  dut_in, busy, done, result_valid, pass, captured, fail_vec
  );

endinterface

// File: rtl/truth_table_sequencer_settle_timer.sv
// Load/count-down settle timer: load arms SETTLE_CYCLES-1, expired is high once the count reaches zero.
module settle_timer
  import truth_table_sequencer_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic expired
);

  localparam int            CW       = cnt_width(SETTLE_CYCLES);
  localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/truth_table_sequencer.sv
// Sweeps every input vector of a gate in ascending order, holds each SETTLE_CYCLES+1 cycles,
// captures the gate output per vector and compares the resulting table against EXPECTED.
module truth_table_sequencer
  import truth_table_sequencer_pkg::*;
#(
  parameter int                           N_INPUTS      = 2,
  parameter int                           SETTLE_CYCLES = 2,
  parameter logic [tt_vecs(N_INPUTS)-1:0] EXPECTED      = 4'b1000
) (
  input logic                     clk,
  input logic                     rst_n,
  truth_table_sequencer_if.slave  bus
);

  localparam logic [N_INPUTS-1:0] LAST_VEC = '1;

  seq_state_t          state;
  logic [N_INPUTS-1:0] vec;
  logic                accept;
  logic                load;
  logic                expired;

  assign accept = (state == IDLE) && bus.start && !bus.abort;
  assign load   = accept || ((state == SAMPLE) && (vec != LAST_VEC));

  settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .expired(expired)
  );

  // An abort or reset in the DONE cycle suppresses the completion pulse.
  assign bus.done = rst_n && !bus.abort && (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      vec              <= '0;
      bus.dut_in       <= '0;
      bus.busy         <= 1'b0;
      bus.result_valid <= 1'b0;
      bus.pass         <= 1'b0;
      bus.captured     <= '0;
      bus.fail_vec     <= '0;
    end else if ((state != IDLE) && bus.abort) begin
      state            <= IDLE;
      bus.busy         <= 1'b0;
      bus.dut_in       <= '0;
      bus.result_valid <= 1'b0;
      bus.pass         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            vec              <= '0;
            bus.dut_in       <= '0;
            bus.busy         <= 1'b1;
            bus.captured     <= '0;
            bus.result_valid <= 1'b0;
            bus.pass         <= 1'b0;
            state            <= SETTLE;
          end
        end
        SETTLE: begin
          if (expired) begin
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          bus.captured[vec] <= bus.dut_out;
          if (vec == LAST_VEC) begin
            bus.dut_in <= '0;
            state      <= DONE;
          end else begin
            vec        <= vec + 1'b1;
            bus.dut_in <= vec + 1'b1;
            state      <= SETTLE;
          end
        end
        DONE: begin
          bus.busy         <= 1'b0;
          bus.result_valid <= 1'b1;
          bus.fail_vec     <= bus.captured ^ EXPECTED;
          bus.pass         <= (bus.captured == EXPECTED);
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
